// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD counter slice: digit width, digit limits,
// the digit type, and a helper that forces an out-of-range digit to zero.
// Optional feature macro used elsewhere in this slice: BCD_COUNTER_DOWN_EN.
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // True when a raw nibble is a legal decimal digit (0..9).
    function automatic logic bcd_is_valid(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

    // Legal digits pass through; codes 10..15 collapse to zero so the
    // register never holds a non-decimal value.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return bcd_is_valid(d) ? d : BCD_ZERO;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// ---------------------------------------------------------------------------
// bcd_digit_step
// Combinational single-digit BCD step. When carry_in is high the digit moves
// one position (up when dir=0, down when dir=1) and carry_out is raised when
// the digit wraps (9->0 going up, 0->9 going down). With carry_in low the
// digit passes through unchanged and carry_out stays low.
// The dir input is tied low by the parent unless BCD_COUNTER_DOWN_EN is set.
//
// Ports:
//   digit      in   4  current digit value (0..9)
//   carry_in   in   1  step request from the lower digit (or count enable)
//   dir        in   1  0 = up, 1 = down
//   next_digit out  4  stepped digit value
//   carry_out  out  1  wrap indication to the next higher digit
// ---------------------------------------------------------------------------
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       carry_in,
    input  logic       dir,
    output bcd_digit_t next_digit,
    output logic       carry_out
);

    // The carry only ripples on when this digit itself wraps, which is what
    // makes digit i move only when all lower digits sit at their wrap value.
    always_comb begin
        next_digit = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (!dir) begin
                if (digit == BCD_MAX) begin
                    next_digit = BCD_ZERO;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == BCD_ZERO) begin
                    next_digit = BCD_MAX;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
// Registered multi-digit BCD counter. A ripple chain of bcd_digit_step
// instances computes the next count every cycle; the register captures it
// on enabled edges. Per-edge priority: clr > load > en > hold.
// Optional feature macro: BCD_COUNTER_DOWN_EN (adds the dir port and
// down-counting; without it the counter only counts up).
//
// Ports:
//   clk        in   1         system clock, rising edge
//   reset      in   1         asynchronous active-high reset
//   clr        in   1         synchronous clear to zero
//   load       in   1         synchronous parallel load of din
//   din        in   4*DIGITS  load value, digit 0 in bits [3:0]
//   en         in   1         count enable, one step per cycle
//   dir        in   1         (BCD_COUNTER_DOWN_EN only) 0 = up, 1 = down
//   q          out  4*DIGITS  registered count, same packing as din
//   carry_out  out  1         registered one-cycle pulse after a full wrap
//   max_tick   out  1         combinational terminal-count flag
//   load_err   out  1         sticky flag: a loaded digit exceeded 9
// ---------------------------------------------------------------------------
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   din,
    input  logic                      en,
`ifdef BCD_COUNTER_DOWN_EN
    input  logic                      dir,
`endif
    output logic [BCD_W*DIGITS-1:0]   q,
    output logic                      carry_out,
    output logic                      max_tick,
    output logic                      load_err
);

    logic [BCD_W*DIGITS-1:0] next_q;
    logic [BCD_W*DIGITS-1:0] load_q;
    logic [DIGITS:0]         chain;
    logic [DIGITS-1:0]       digit_bad;
    logic [DIGITS-1:0]       digit_nine;
    logic                    step_dir;

`ifdef BCD_COUNTER_DOWN_EN
    logic [DIGITS-1:0]       digit_zero;
    assign step_dir = dir;
`else
    assign step_dir = 1'b0;
`endif

    // The enable is the carry into digit 0, so digit 0 steps on every
    // enabled cycle and the chain's final carry marks a full wrap.
    assign chain[0] = en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (q[BCD_W*i +: BCD_W]),
            .carry_in   (chain[i]),
            .dir        (step_dir),
            .next_digit (next_q[BCD_W*i +: BCD_W]),
            .carry_out  (chain[i+1])
        );

        assign load_q[BCD_W*i +: BCD_W] = bcd_sanitize(din[BCD_W*i +: BCD_W]);
        assign digit_bad[i]  = !bcd_is_valid(din[BCD_W*i +: BCD_W]);
        assign digit_nine[i] = (q[BCD_W*i +: BCD_W] == BCD_MAX);
`ifdef BCD_COUNTER_DOWN_EN
        assign digit_zero[i] = (q[BCD_W*i +: BCD_W] == BCD_ZERO);
`endif
    end

    // Terminal count follows the register directly so a cascaded stage can
    // see it in the same cycle; the terminal value depends on direction.
`ifdef BCD_COUNTER_DOWN_EN
    assign max_tick = dir ? (&digit_zero) : (&digit_nine);
`else
    assign max_tick = &digit_nine;
`endif

    // Count register. The carry pulse is only ever raised by a wrapping
    // enabled step, so every other branch drops it back to zero. load_err
    // is sticky: a clean load leaves an earlier error visible until clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            carry_out <= 1'b0;
            load_err  <= 1'b0;
        end else if (clr) begin
            q         <= '0;
            carry_out <= 1'b0;
            load_err  <= 1'b0;
        end else if (load) begin
            q         <= load_q;
            carry_out <= 1'b0;
            if (|digit_bad) begin
                load_err <= 1'b1;
            end
        end else if (en) begin
            q         <= next_q;
            carry_out <= chain[DIGITS];
        end else begin
            carry_out <= 1'b0;
        end
    end

endmodule
